// File: rtl/apb_master.sv
// APB master: takes single-beat requests from a local requester and runs them
// on a two-slave APB bus (SETUP then ACCESS), with an optional wait-state
// timeout that aborts a transfer whose slave never becomes ready.
module apb_master #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       transfer,
    input  logic       wr,
    input  logic [7:0] addr_in,
    input  logic [7:0] wdata_in,
    input  logic       PREADY1,
    input  logic       PREADY2,
    input  logic [7:0] PRDATA1,
    input  logic [7:0] PRDATA2,
    output logic       PSEL1,
    output logic       PSEL2,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    output logic [7:0] rdata_out,
    output logic       done,
    output logic       error,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    // Counter must be able to hold TIMEOUT itself; keep at least one bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic          ready_sel;
    logic [7:0]    rdata_sel;
    logic          timeout_hit;
    logic          accept, complete, abort;
    logic          slave2_next;

    // Only the slave addressed by the latched PADDR[7] is ever observed.
    always_comb begin
        ready_sel   = PADDR[7] ? PREADY2 : PREADY1;
        rdata_sel   = PADDR[7] ? PRDATA2 : PRDATA1;
        timeout_hit = (TIMEOUT > 0) && (wait_cnt == TMAX);
        slave2_next = accept ? addr_in[7] : PADDR[7];
    end

    // Next-state logic; a ready slave takes priority over the timeout.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (ready_sel) begin
                    complete = 1'b1;
                    if (transfer) begin
                        accept     = 1'b1;
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Request fields are captured only when a request is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PWRITE <= 1'b0;
            PADDR  <= 8'h00;
            PWDATA <= 8'h00;
        end else if (accept) begin
            PWRITE <= wr;
            PADDR  <= addr_in;
            PWDATA <= wdata_in;
        end
    end

    // Bus strobes and status flags, registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PSEL1   <= 1'b0;
            PSEL2   <= 1'b0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            PSEL1   <= (state_next != IDLE) && !slave2_next;
            PSEL2   <= (state_next != IDLE) &&  slave2_next;
            PENABLE <= (state_next == ACCESS);
            busy    <= (state_next != IDLE);
            done    <= complete || abort;
            error   <= abort;
        end
    end

    // Read data is updated only by a successful read completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   rdata_out <= 8'h00;
        else if (complete && !PWRITE) rdata_out <= rdata_sel;
    end

    // Wait-state counter: restarts with every accepted request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (accept)
            wait_cnt <= '0;
        else if (state == ACCESS && !ready_sel && !timeout_hit)
            wait_cnt <= wait_cnt + 1'b1;
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios plus randomized transfers judged
// against a transfer-level model (ACCESS cycle count, error, read data).
module tb_apb_master;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       transfer = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr_in = 8'h00;
    logic [7:0] wdata_in = 8'h00;
    logic       PREADY1 = 1'b0, PREADY2 = 1'b0;
    logic [7:0] PRDATA1 = 8'h00, PRDATA2 = 8'h00;
    logic       PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, rdata_out;
    logic       done, error, busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rdata = 8'h00;

    apb_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .transfer(transfer), .wr(wr),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .PREADY1(PREADY1), .PREADY2(PREADY2),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .rdata_out(rdata_out),
        .done(done), .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    // {PSEL1, PSEL2, PENABLE, done, error, busy}
    function automatic logic [5:0] ctl();
        return {PSEL1, PSEL2, PENABLE, done, error, busy};
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (ctl() !== 6'b0 || PWRITE !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b pwrite %b want 000000 0", ctl(), PWRITE);
        end
        checks++;
        if (PADDR !== 8'h00 || PWDATA !== 8'h00 || rdata_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 00 00 00", PADDR, PWDATA, rdata_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_rdata = 8'h00;
        cycle();
        checks++;
        if (ctl() !== 6'b0) begin
            errors++;
            $display("FAIL reset_release_idle got %b want 000000", ctl());
        end
    endtask

    // One transfer. The bench acts as the selected slave, asserting PREADY
    // after 'waits' ACCESS cycles; the other slave toggles randomly.
    task automatic do_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input int waits, input logic [7:0] prd, input bit hold,
                           input string name);
        int   exp_acc, setup_n, acc_n, done_k;
        bit   exp_err, err_seen, other_sel, unstable, busy_bad, ready_now;
        logic s, sel_me;
        logic [7:0] rd_seen;
        s        = a[7];
        exp_acc  = (waits <= TIMEOUT) ? waits + 1 : TIMEOUT + 1;
        exp_err  = (waits > TIMEOUT);
        setup_n  = 0; acc_n = 0; done_k = -1;
        err_seen = 0; other_sel = 0; unstable = 0; busy_bad = 0;
        rd_seen  = 8'h00;
        @(negedge clk);
        transfer = 1'b1; wr = w; addr_in = a; wdata_in = d;
        PREADY1 = 1'b0; PREADY2 = 1'b0;
        PRDATA1 = s ? 8'($urandom) : prd;
        PRDATA2 = s ? prd : 8'($urandom);
        for (int k = 1; k <= 60; k++) begin
            cycle();
            sel_me = s ? PSEL2 : PSEL1;
            if (s ? PSEL1 : PSEL2) other_sel = 1;
            if (done) begin
                done_k   = k;
                err_seen = error;
                rd_seen  = rdata_out;
                break;
            end
            if (sel_me && !PENABLE) setup_n++;
            if (sel_me && PENABLE) acc_n++;
            if (sel_me && (PADDR !== a || PWRITE !== w || PWDATA !== d)) unstable = 1;
            if (busy !== 1'b1 || !sel_me) busy_bad = 1;
            ready_now = sel_me && PENABLE && (acc_n > waits);
            if (!hold || ready_now) transfer = 1'b0;
            if (s) begin
                PREADY2 = ready_now; PREADY1 = 1'($urandom); PRDATA1 = 8'($urandom);
            end else begin
                PREADY1 = ready_now; PREADY2 = 1'($urandom); PRDATA2 = 8'($urandom);
            end
        end
        transfer = 1'b0; PREADY1 = 1'b0; PREADY2 = 1'b0;
        if (!w && !exp_err) exp_rdata = prd;

        checks++;
        if (done_k !== exp_acc + 2) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, done_k, exp_acc + 2);
        end
        checks++;
        if (setup_n !== 1 || acc_n !== exp_acc) begin
            errors++;
            $display("FAIL %s phases got setup %0d access %0d want 1 %0d", name, setup_n, acc_n, exp_acc);
        end
        checks++;
        if (err_seen !== exp_err) begin
            errors++;
            $display("FAIL %s error got %b want %b", name, err_seen, exp_err);
        end
        checks++;
        if (other_sel || unstable || busy_bad) begin
            errors++;
            $display("FAIL %s bus other_sel %b unstable %b busy_bad %b want 0 0 0", name, other_sel, unstable, busy_bad);
        end
        checks++;
        if (rd_seen !== exp_rdata) begin
            errors++;
            $display("FAIL %s rdata got %h want %h", name, rd_seen, exp_rdata);
        end
        cycle();
        checks++;
        if (ctl() !== 6'b0) begin
            errors++;
            $display("FAIL %s after_done got %b want 000000", name, ctl());
        end
    endtask

    task automatic test_write_basic();
        do_xfer(1'b1, 8'h03, 8'hA5, 0, 8'h00, 1'b0, "write_basic");
    endtask

    task automatic test_read_wait();
        do_xfer(1'b0, 8'h85, 8'h00, 3, 8'h3C, 1'b0, "read_wait3");
    endtask

    task automatic test_held_request();
        do_xfer(1'b0, 8'h44, 8'h19, 5, 8'hE7, 1'b1, "read_held");
    endtask

    task automatic test_timeout();
        do_xfer(1'b0, 8'h02, 8'h00, 1000, 8'h99, 1'b0, "timeout");
        do_xfer(1'b0, 8'h8A, 8'h00, TIMEOUT, 8'h6D, 1'b0, "ready_at_limit");
        do_xfer(1'b1, 8'h0B, 8'h77, TIMEOUT + 1, 8'h00, 1'b1, "timeout_held");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        transfer = 1'b1; wr = 1'b1; addr_in = 8'h01; wdata_in = 8'h5A;
        PREADY1 = 1'b1; PREADY2 = 1'b0; PRDATA2 = 8'hC3;
        cycle();
        checks++;
        if (ctl() !== 6'b100001) begin
            errors++;
            $display("FAIL b2b_setup1 got %b want 100001", ctl());
        end
        cycle();
        checks++;
        if (ctl() !== 6'b101001 || PWDATA !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_access1 got %b %h want 101001 5a", ctl(), PWDATA);
        end
        wr = 1'b0; addr_in = 8'h81; wdata_in = 8'h00;
        cycle();
        checks++;
        if (ctl() !== 6'b010101 || PADDR !== 8'h81 || PWRITE !== 1'b0) begin
            errors++;
            $display("FAIL b2b_setup2 got %b %h %b want 010101 81 0", ctl(), PADDR, PWRITE);
        end
        transfer = 1'b0; PREADY1 = 1'b0; PREADY2 = 1'b1;
        cycle();
        checks++;
        if (ctl() !== 6'b011001) begin
            errors++;
            $display("FAIL b2b_access2 got %b want 011001", ctl());
        end
        cycle();
        exp_rdata = 8'hC3;
        checks++;
        if (ctl() !== 6'b000100 || rdata_out !== exp_rdata) begin
            errors++;
            $display("FAIL b2b_done got %b %h want 000100 %h", ctl(), rdata_out, exp_rdata);
        end
        PREADY2 = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        saw_done = 0;
        @(negedge clk);
        transfer = 1'b1; wr = 1'b0; addr_in = 8'h02; PREADY1 = 1'b0; PREADY2 = 1'b1;
        cycle();
        transfer = 1'b0;
        repeat (3) cycle();
        #2 reset = 1'b0;
        #1;
        exp_rdata = 8'h00;
        checks++;
        if (ctl() !== 6'b0 || PWRITE !== 1'b0 || PADDR !== 8'h00 || PWDATA !== 8'h00 || rdata_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async got %b %b %h %h %h want all zero", ctl(), PWRITE, PADDR, PWDATA, rdata_out);
        end
        @(negedge clk);
        reset = 1'b1;
        PREADY2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (done || error || busy) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid_quiet got activity 1 want 0");
        end
        do_xfer(1'b1, 8'h10, 8'h3E, 1, 8'h00, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [7:0] a, d, prd;
        logic       w;
        int         waits;
        for (int n = 0; n < 24; n++) begin
            w     = 1'($urandom);
            a     = 8'($urandom);
            d     = 8'($urandom);
            prd   = 8'($urandom);
            waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                                 : $urandom_range(0, 4);
            do_xfer(w, a, d, waits, prd, 1'($urandom), "random");
            repeat ($urandom_range(0, 2)) cycle();
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_held_request();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
